// File: rtl/bip_program_loader.sv
// BIP program loader: assembles UART bytes into 16-bit words, writes them
// to instruction memory and releases the BIP core once HALT is stored.
// Ports: i_clock/i_reset (sync, active-high); i_rx_data/i_rx_valid from
// UART RX; o_insmem_wr_en/addr/data to instruction memory;
// o_cpu_reset/o_cpu_valid to the core; o_word_count; o_error (sticky).
// Optional macro BIP_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module bip_program_loader #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_BYTE            = 8,
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter logic [NB_BYTE-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_insmem_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_insmem_addr,
  output logic [NB_DATA-1:0]            o_insmem_data,
  output logic                          o_cpu_reset,
  output logic                          o_cpu_valid,
  output logic [LOG2_N_INSMEM_ADDR:0]   o_word_count,
  output logic                          o_error
);

`ifdef BIP_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_CHK, S_RUN, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_RUN, S_ERR
  } state_t;
`endif

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR =
    LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1);

  state_t                          state_q;
  logic [NB_DATA-NB_BYTE-1:0]      hi_q;
  logic                            wr_en_q;
  logic [LOG2_N_INSMEM_ADDR-1:0]   addr_q;
  logic [NB_DATA-1:0]              data_q;
  logic                            cpu_reset_q;
  logic                            cpu_valid_q;
  logic [LOG2_N_INSMEM_ADDR:0]     count_q;
  logic                            error_q;
`ifdef BIP_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]              chk_q;
`endif

  logic [NB_DATA-1:0] word_d;
  logic               halt_d;

  assign word_d = {hi_q, i_rx_data};
  assign halt_d = (word_d[NB_DATA-1 -: NB_OPCODE] == '0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cpu_reset_q <= 1'b1;
      cpu_valid_q <= 1'b0;
      count_q     <= '0;
      error_q     <= 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      // Address/count advance on the edge that ends the write pulse.
      // The last address is never stepped past, so it cannot wrap.
      if (wr_en_q) begin
        count_q <= count_q + 1'b1;
        if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
      end
      // Release one cycle after the HALT write pulse.
      if (state_q == S_RUN) begin
        cpu_reset_q <= 1'b0;
        cpu_valid_q <= 1'b1;
      end
      if (state_q == S_ERR) error_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
            state_q <= S_HI;
            addr_q  <= '0;
            count_q <= '0;
`ifdef BIP_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
          end
        end
        S_HI: begin
          if (i_rx_valid) begin
            hi_q    <= i_rx_data;
            state_q <= S_LO;
`ifdef BIP_LOADER_CHECKSUM_EN
            chk_q   <= chk_q ^ i_rx_data;
`endif
          end
        end
        S_LO: begin
          if (i_rx_valid) begin
            data_q  <= word_d;
            wr_en_q <= 1'b1;
`ifdef BIP_LOADER_CHECKSUM_EN
            chk_q   <= chk_q ^ i_rx_data;
`endif
            // HALT wins over memory-full.
            if (halt_d) begin
`ifdef BIP_LOADER_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q <= S_RUN;
`endif
            end else if (addr_q == LAST_ADDR) begin
              state_q <= S_ERR;
            end else begin
              state_q <= S_HI;
            end
          end
        end
`ifdef BIP_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (i_rx_valid) begin
            if (i_rx_data == chk_q) begin
              state_q     <= S_RUN;
              cpu_reset_q <= 1'b0;
              cpu_valid_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        S_RUN: state_q <= S_RUN;
        S_ERR: state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_insmem_wr_en = wr_en_q;
  assign o_insmem_addr  = addr_q;
  assign o_insmem_data  = data_q;
  assign o_cpu_reset    = cpu_reset_q;
  assign o_cpu_valid    = cpu_valid_q;
  assign o_word_count   = count_q;
  assign o_error        = error_q;

endmodule
